// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
//   Shares a single req/gnt/rvalid memory port between the instruction-fetch
//   and data (LSU) interfaces of the core.  A request is forwarded in the
//   same cycle it is selected.  Data has fixed priority over fetch, except
//   when a starvation guard forces a fetch.  An in-order source FIFO steers
//   each bus response back to the host that issued the matching request.
//
// Ports
//   clk_i, rst_ni         clock, synchronous active-low reset
//   instr_*               fetch host: req/addr in, gnt/rvalid/rdata/err out
//   data_*                LSU host: req/we/be/addr/wdata in, gnt/rvalid/rdata/err out
//   bus_*                 shared port: req/we/be/addr/wdata out, gnt/rvalid/rdata/err in
//   protocol_err_o        sticky flag: a response arrived with nothing outstanding
//
// Handshake: a request transfers on a cycle where req=1 and gnt=1 (exactly one
// transfer per such cycle).  A requester holds req and its fields stable until
// gnt.  Responses carry no back-pressure: rvalid is a one-cycle pulse, and
// responses come back in the same order as the grants.

module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        protocol_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned StvW = $clog2(StarveLimit + 1);

    // Source FIFO entry: 0 = fetch, 1 = data.
    logic [MaxOutstanding-1:0] src_fifo;
    logic [PtrW-1:0]           wr_ptr;
    logic [PtrW-1:0]           rd_ptr;
    logic [CntW-1:0]           count;
    logic                      lock_q;
    logic                      lock_data_q;
    logic [StvW-1:0]           starve_cnt;
    logic                      protocol_err_q;

    logic sel_valid;
    logic sel_data;
    logic grant;
    logic rsp_valid;
    logic head_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Owner selection.  A stalled request stays locked to its owner so the
    // address presented to the bus never changes underneath a pending grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 1'b0;
        if (rst_ni) begin
            if (lock_q) begin
                sel_valid = 1'b1;
                sel_data  = lock_data_q;
            end else if (count != CntW'(MaxOutstanding)) begin
                if (data_req_i && !(instr_req_i && starve_cnt == StvW'(StarveLimit))) begin
                    sel_valid = 1'b1;
                    sel_data  = 1'b1;
                end else if (instr_req_i) begin
                    sel_valid = 1'b1;
                end
            end
        end
    end

    assign bus_req_o   = sel_valid;
    assign bus_we_o    = sel_valid & sel_data & data_we_i;
    assign bus_be_o    = !sel_valid ? 4'h0  : (sel_data ? data_be_i    : 4'hF);
    assign bus_addr_o  = !sel_valid ? 32'h0 : (sel_data ? data_addr_i  : instr_addr_i);
    assign bus_wdata_o = (sel_valid && sel_data) ? data_wdata_i : 32'h0;

    assign grant       = sel_valid & bus_gnt_i;
    assign data_gnt_o  = grant & sel_data;
    assign instr_gnt_o = grant & ~sel_data;

    // Responses with nothing outstanding are dropped here and only flagged.
    assign head_data      = src_fifo[rd_ptr];
    assign rsp_valid      = rst_ni & bus_rvalid_i & (count != '0);
    assign instr_rvalid_o = rsp_valid & ~head_data;
    assign data_rvalid_o  = rsp_valid & head_data;
    assign instr_rdata_o  = bus_rdata_i;
    assign data_rdata_o   = bus_rdata_i;
    assign instr_err_o    = bus_err_i;
    assign data_err_o     = bus_err_i;
    assign protocol_err_o = protocol_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            src_fifo       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            lock_q         <= 1'b0;
            lock_data_q    <= 1'b0;
            starve_cnt     <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if (grant) begin
                src_fifo[wr_ptr] <= sel_data;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (rsp_valid) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (grant && !rsp_valid) begin
                count <= count + CntW'(1);
            end else if (!grant && rsp_valid) begin
                count <= count - CntW'(1);
            end

            if (sel_valid && !bus_gnt_i) begin
                lock_q      <= 1'b1;
                lock_data_q <= sel_data;
            end else begin
                lock_q      <= 1'b0;
            end

            // Counts data grants that overtook a waiting fetch.
            if (!instr_req_i || instr_gnt_o) begin
                starve_cnt <= '0;
            end else if (data_gnt_o && starve_cnt != StvW'(StarveLimit)) begin
                starve_cnt <= starve_cnt + StvW'(1);
            end

            if (bus_rvalid_i && count == '0) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

endmodule
